skolem_spec_checker: RTL

//  Sequential checker for a combinational Skolem candidate y = f(x) of the bvslt/bvor family.
//  It sweeps every input vector x = {a,b}, drives x to the external candidate and samples y after
//  a settle window. It evaluates the spec F(a,b,y) = $signed(a | {{W-1{1'b0}},y}) < $signed(b).
//  It flags x when some y satisfies F but the candidate's y does not. Sits on the bench/FPGA harness.

---
 rtl/skolem_spec_checker_pkg.sv | 38 +++
 rtl/skolem_spec_checker_spec_eval.sv | 32 +++
 rtl/skolem_spec_checker.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/skolem_spec_checker_pkg.sv
// +----------------------------------------------------------------------------+
// | skc_pkg: shared types and spec function for skolem_spec_checker            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package skc_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRIVE  = 3'd1,
      WAIT   = 3'd2,
      SAMPLE = 3'd3,
      DONE   = 3'd4
   } skc_state_e;

   localparam int SKC_MAX_W = 16;
   // Terminal sweep vector is all-ones; the top slices this to its own 2*W width.
   localparam logic [2*SKC_MAX_W-1:0] SKC_TERM_X = {(2*SKC_MAX_W){1'b1}};

   // F(a,b,y) = $signed(a | y) < $signed(b) on w bits; flipping the sign bit
   // turns a two's-complement compare into an unsigned one.
   function automatic logic skc_spec(input logic [SKC_MAX_W-1:0] a,
                                     input logic [SKC_MAX_W-1:0] b,
                                     input logic                 y,
                                     input int                   w);
      logic [SKC_MAX_W-1:0] mask;
      logic [SKC_MAX_W-1:0] sgn;
      logic [SKC_MAX_W-1:0] av;
      mask = (SKC_MAX_W'(1) << w) - SKC_MAX_W'(1);
      sgn  = SKC_MAX_W'(1) << (w - 1);
      av   = (a | {{(SKC_MAX_W-1){1'b0}}, y}) & mask;
      return ((av ^ sgn) < ((b & mask) ^ sgn));
   endfunction

endpackage

`default_nettype wire

// File: rtl/skolem_spec_checker_spec_eval.sv
// +----------------------------------------------------------------------------+
// | skc_spec_eval: evaluates F for the candidate y and for both constant y     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module skc_spec_eval
   import skc_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         y_i,
   output logic         f_y_o,
   output logic         f_0_o,
   output logic         f_1_o
);

   logic [SKC_MAX_W-1:0] a_ext;
   logic [SKC_MAX_W-1:0] b_ext;

   assign a_ext = SKC_MAX_W'(a_i);
   assign b_ext = SKC_MAX_W'(b_i);

   assign f_y_o = skc_spec(a_ext, b_ext, y_i,  W);
   assign f_0_o = skc_spec(a_ext, b_ext, 1'b0, W);
   assign f_1_o = skc_spec(a_ext, b_ext, 1'b1, W);

endmodule

`default_nettype wire

// File: rtl/skolem_spec_checker.sv
// +----------------------------------------------------------------------------+
// | skolem_spec_checker: sweeps all x={a,b}, checks candidate y=f(x) against F |
// | Option: SKC_HALT_ON_FAIL_EN stops the sweep at the first failing vector.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module skolem_spec_checker
   import skc_pkg::*;
#(
   parameter int W          = 4,
   parameter int SETTLE_CYC = 2,
   parameter int CNT_W      = 2*W+1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [2*W-1:0]   cand_x,
   input  logic             cand_y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] sat_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [2*W-1:0]   first_fail
);

   localparam int XW = 2*W;
   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);
   localparam logic [XW-1:0] TERM_X      = SKC_TERM_X[XW-1:0];

   skc_state_e       state_q,  state_d;
   logic [XW-1:0]    cand_x_q, cand_x_d;
   logic [SW-1:0]    settle_q, settle_d;
   logic [CNT_W-1:0] sat_q,    sat_d;
   logic [CNT_W-1:0] fail_q,   fail_d;
   logic [XW-1:0]    first_q,  first_d;

   logic f_y, f_0, f_1;
   logic ex, vec_fail;

   skc_spec_eval #(.W(W)) u_eval (
      .a_i   (cand_x_q[XW-1:W]),
      .b_i   (cand_x_q[W-1:0]),
      .y_i   (cand_y),
      .f_y_o (f_y),
      .f_0_o (f_0),
      .f_1_o (f_1)
   );

   assign ex       = f_0 | f_1;
   assign vec_fail = ex & ~f_y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cand_x_q <= '0;
         settle_q <= '0;
         sat_q    <= '0;
         fail_q   <= '0;
         first_q  <= '0;
      end else begin
         state_q  <= state_d;
         cand_x_q <= cand_x_d;
         settle_q <= settle_d;
         sat_q    <= sat_d;
         fail_q   <= fail_d;
         first_q  <= first_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cand_x_d = cand_x_q;
      settle_d = settle_q;
      sat_d    = sat_q;
      fail_d   = fail_q;
      first_d  = first_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               cand_x_d = '0;
               sat_d    = '0;
               fail_d   = '0;
               first_d  = '0;
               state_d  = DRIVE;
            end
         end
         DRIVE: begin
            settle_d = SETTLE_LOAD;
            state_d  = WAIT;
         end
         WAIT: begin
            if (settle_q == '0) begin
               state_d = SAMPLE;
            end else begin
               settle_d = settle_q - SW'(1);
            end
         end
         SAMPLE: begin
`ifdef SKC_HALT_ON_FAIL_EN
            // Halting vector is left out of sat_cnt; cand_x keeps pointing at it.
            if (vec_fail) begin
               fail_d  = fail_q + CNT_W'(1);
               first_d = cand_x_q;
               state_d = DONE;
            end else begin
               sat_d = sat_q + CNT_W'(ex);
               if (cand_x_q == TERM_X) begin
                  state_d = DONE;
               end else begin
                  cand_x_d = cand_x_q + XW'(1);
                  state_d  = DRIVE;
               end
            end
`else
            sat_d = sat_q + CNT_W'(ex);
            if (vec_fail) begin
               fail_d = fail_q + CNT_W'(1);
               if (fail_q == '0) begin
                  first_d = cand_x_q;
               end
            end
            if (cand_x_q == TERM_X) begin
               state_d = DONE;
            end else begin
               cand_x_d = cand_x_q + XW'(1);
               state_d  = DRIVE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   assign cand_x     = cand_x_q;
   assign busy       = (state_q == DRIVE) || (state_q == WAIT) || (state_q == SAMPLE);
   assign done       = (state_q == DONE);
   assign pass       = done && (fail_q == '0);
   assign sat_cnt    = sat_q;
   assign fail_cnt   = fail_q;
   assign first_fail = first_q;

endmodule

`default_nettype wire
